// File: rtl/simple_bus_arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// Holds the arbiter state encoding, the index-width rule and the round-robin winner search.
package simple_bus_arb_pkg;

  localparam int unsigned MAX_MST   = 8;
  localparam int unsigned MAX_IDX_W = 3;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    if (n <= 32'd2) begin
      w = 32'd1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

  // Scan from last+1 with wrap; the lowest distance wins, so the loop runs far-to-near.
  function automatic int unsigned rr_pick(input logic [MAX_MST-1:0] req,
                                          input int unsigned        last,
                                          input int unsigned        n_mst);
    int unsigned pick;
    int unsigned idx;
    logic [MAX_IDX_W-1:0] sel;
    pick = last;
    for (int k = MAX_MST; k > 0; k--) begin
      idx = last + 32'(k);
      if (idx >= n_mst) begin
        idx = idx - n_mst;
      end else begin
        idx = idx;
      end
      sel = idx[MAX_IDX_W-1:0];
      if ((32'(k) <= n_mst) && req[sel]) begin
        pick = idx;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/simple_if.sv
// Simple memory-port interface: the master drives address, strobes and write data,
// the slave returns read data a fixed number of cycles after a read strobe.
interface simple_if #(
  parameter int ADDR_BIT_WIDTH = 2,
  parameter int DATA_BIT_WIDTH = 8
) ();
  logic [ADDR_BIT_WIDTH-1:0] addr;
  logic                      rd_req;
  logic                      wr_req;
  logic [DATA_BIT_WIDTH-1:0] wr_data;
  logic [DATA_BIT_WIDTH-1:0] rd_data;

  modport mst_port (output addr, output rd_req, output wr_req, output wr_data, input rd_data);
  modport slv_port (input addr, input rd_req, input wr_req, input wr_data, output rd_data);
endinterface

// File: rtl/simple_bus_rd_tag_pipe.sv
// Delay line of {valid, issuer index}, as deep as the slave read latency, so read
// data can be steered back to the master that issued the read.
module simple_bus_rd_tag_pipe #(
  parameter int RD_LAT = 1,
  parameter int IDX_W  = 2
) (
  input  logic             i_clk,
  input  logic             i_async_rst,
  input  logic             i_vld,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_vld,
  output logic [IDX_W-1:0] o_idx
);
  logic [RD_LAT-1:0]            r_vld;
  logic [RD_LAT-1:0][IDX_W-1:0] r_idx;

  // Shift the tag one stage per cycle; reset drops every in-flight read.
  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      r_vld <= '0;
      r_idx <= '0;
    end else begin
      r_vld[0] <= i_vld;
      r_idx[0] <= i_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_idx[i] <= r_idx[i-1];
      end
    end
  end

  assign o_vld = r_vld[RD_LAT-1];
  assign o_idx = r_idx[RD_LAT-1];
endmodule

// File: rtl/simple_bus_rr_arb.sv
// Round-robin arbiter sharing one simple_if slave port among N_MST masters.
// Optional grant quota (pre-emption after QUOTA cycles) enabled by SIMPLE_BUS_ARB_QUOTA_EN.
module simple_bus_rr_arb
  import simple_bus_arb_pkg::*;
#(
  parameter int N_MST          = 4,
  parameter int ADDR_BIT_WIDTH = 2,
  parameter int DATA_BIT_WIDTH = 8,
  parameter int RD_LAT         = 1,
  parameter int QUOTA          = 4
) (
  input  logic                                    i_clk,
  input  logic                                    i_async_rst,
  input  logic [N_MST-1:0]                        i_req,
  output logic [N_MST-1:0]                        o_gnt,
  input  logic [N_MST-1:0][ADDR_BIT_WIDTH-1:0]    i_mst_addr,
  input  logic [N_MST-1:0]                        i_mst_rd_req,
  input  logic [N_MST-1:0]                        i_mst_wr_req,
  input  logic [N_MST-1:0][DATA_BIT_WIDTH-1:0]    i_mst_wr_data,
  output logic [N_MST-1:0]                        o_rd_vld,
  output logic [DATA_BIT_WIDTH-1:0]               o_rd_data,
  simple_if.mst_port                              if_bus
);
  localparam int unsigned      IDX_W       = idx_width(N_MST);
  localparam logic [N_MST-1:0] LP_ONE      = {{(N_MST-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] LP_LAST_RST = IDX_W'(N_MST - 1);

  arb_state_e         r_state;
  arb_state_e         w_nxt_state;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   w_nxt_owner;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   w_nxt_last;
  logic [N_MST-1:0]   r_gnt;
  logic [N_MST-1:0]   w_nxt_gnt;
  logic [MAX_MST-1:0] w_req_pad;
  logic [IDX_W-1:0]   w_winner;
  logic [N_MST-1:0]   w_owner_oh;
  logic               w_any_req;
  logic               w_owner_req;
  logic               w_take;
  logic               w_release;
  logic               w_tag_vld;
  logic [IDX_W-1:0]   w_tag_idx;

  assign w_req_pad   = MAX_MST'(i_req);
  assign w_winner    = IDX_W'(rr_pick(w_req_pad, 32'(r_last), N_MST));
  assign w_owner_oh  = LP_ONE << r_owner;
  assign w_any_req   = |i_req;
  assign w_owner_req = |(i_req & w_owner_oh);
  assign o_gnt       = r_gnt;

`ifdef SIMPLE_BUS_ARB_QUOTA_EN
  localparam int unsigned     LP_QW        = $clog2(QUOTA) + 1;
  localparam logic [LP_QW-1:0] LP_QUOTA_TOP = LP_QW'(QUOTA - 1);

  logic [LP_QW-1:0] r_quota_cnt;
  logic             w_others;

  assign w_others = |(i_req & ~w_owner_oh);

  // Consecutive-cycle counter for the current owner; saturates when nobody else waits.
  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      r_quota_cnt <= '0;
    end else if (w_take) begin
      r_quota_cnt <= '0;
    end else if ((r_state == ARB_BUSY) && (r_quota_cnt != LP_QUOTA_TOP)) begin
      r_quota_cnt <= r_quota_cnt + LP_QW'(1);
    end else begin
      r_quota_cnt <= r_quota_cnt;
    end
  end
`else
  logic w_unused_quota;
  assign w_unused_quota = (QUOTA != 0);
`endif

  // State register: arbiter state, owner, round-robin pointer and the registered grant.
  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      r_state <= ARB_IDLE;
      r_owner <= '0;
      r_last  <= LP_LAST_RST;
      r_gnt   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_owner <= w_nxt_owner;
      r_last  <= w_nxt_last;
      r_gnt   <= w_nxt_gnt;
    end
  end

  // Next-state decision: take a new winner, release the bus, or hold the current owner.
  always_comb begin
    w_take    = 1'b0;
    w_release = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_any_req) begin
          w_take = 1'b1;
        end else begin
          w_take = 1'b0;
        end
      end
      ARB_BUSY: begin
        if (!w_owner_req) begin
          if (w_any_req) begin
            w_take = 1'b1;
          end else begin
            w_release = 1'b1;
          end
        end else begin
`ifdef SIMPLE_BUS_ARB_QUOTA_EN
          if ((r_quota_cnt == LP_QUOTA_TOP) && w_others) begin
            w_take = 1'b1;
          end else begin
            w_take = 1'b0;
          end
`else
          w_take = 1'b0;
`endif
        end
      end
      default: begin
        w_release = 1'b1;
      end
    endcase

    w_nxt_state = r_state;
    w_nxt_owner = r_owner;
    w_nxt_last  = r_last;
    w_nxt_gnt   = r_gnt;
    if (w_take) begin
      w_nxt_state = ARB_BUSY;
      w_nxt_owner = w_winner;
      w_nxt_last  = w_winner;
      w_nxt_gnt   = LP_ONE << w_winner;
    end else if (w_release) begin
      w_nxt_state = ARB_IDLE;
      w_nxt_gnt   = '0;
    end else begin
      w_nxt_state = r_state;
    end
  end

  // Output decode: forward the owner's access to the slave; only granted strobes pass.
  always_comb begin
    if (r_state == ARB_BUSY) begin
      if_bus.addr    = i_mst_addr[r_owner];
      if_bus.wr_data = i_mst_wr_data[r_owner];
      if_bus.rd_req  = |(i_mst_rd_req & r_gnt);
      if_bus.wr_req  = |(i_mst_wr_req & r_gnt);
    end else begin
      if_bus.addr    = '0;
      if_bus.wr_data = '0;
      if_bus.rd_req  = 1'b0;
      if_bus.wr_req  = 1'b0;
    end

    if (w_tag_vld) begin
      o_rd_vld = LP_ONE << w_tag_idx;
    end else begin
      o_rd_vld = '0;
    end
  end

  assign o_rd_data = if_bus.rd_data;

  simple_bus_rd_tag_pipe #(
    .RD_LAT (RD_LAT),
    .IDX_W  (IDX_W)
  ) u_rd_tag_pipe (
    .i_clk       (i_clk),
    .i_async_rst (i_async_rst),
    .i_vld       (if_bus.rd_req),
    .i_idx       (r_owner),
    .o_vld       (w_tag_vld),
    .o_idx       (w_tag_idx)
  );
endmodule

// File: doc/simple_bus_rr_arb.md
Name: simple_bus_rr_arb

Overview:
- Round-robin arbiter sharing one simple_if slave memory port among N_MST requesting masters.
- Sits between several master engines and the slave memory.
- Grants one master at a time, forwards the granted master's address, read-request, write-request and write data to the slave.
- Routes read data back to the issuing master using a fixed-latency tag pipeline.

Parameters:
- N_MST, 4, number of masters (2..8).
- ADDR_BIT_WIDTH, 2, address bit width.
- DATA_BIT_WIDTH, 8, data bit width.
- RD_LAT, 1, slave read latency in cycles, from rd_req to rd_data valid (>=1).
- QUOTA, 4, maximum consecutive granted cycles when others wait (used only with the optional feature).

Ports:
- i_clk  in  1  clock.
- i_async_rst  in  1  reset; asynchronous assertion, active-high.
- i_req  in  N_MST  per-master bus request; held high while the master wants the bus.
- o_gnt  out  N_MST  one-hot grant, registered.
- i_mst_addr  in  N_MST x ADDR_BIT_WIDTH  per-master address.
- i_mst_rd_req  in  N_MST  per-master read strobe; valid only while granted.
- i_mst_wr_req  in  N_MST  per-master write strobe; valid only while granted.
- i_mst_wr_data  in  N_MST x DATA_BIT_WIDTH  per-master write data.
- o_rd_vld  out  N_MST  one-hot read-data-valid back to the issuer.
- o_rd_data  out  DATA_BIT_WIDTH  read data, broadcast to all masters.
- if_bus  simple_if.mst_port  -  slave side: addr, rd_req, wr_req, wr_data out; rd_data in.

Behaviour:
- Reset (asynchronous, active-high):
  - State=ARB_IDLE, o_gnt=0, last-owner pointer=N_MST-1, tag pipeline cleared, o_rd_vld=0.
  - if_bus.rd_req=0 and if_bus.wr_req=0 while in reset.
- States:
  - ARB_IDLE: no owner.
  - ARB_BUSY: owner index r_owner valid.
- Winner selection (combinational):
  - Scan first requester starting at last_owner+1, modulo N_MST.
- ARB_IDLE:
  - If any i_req, next edge: ARB_BUSY, r_owner=winner, o_gnt=onehot(winner), last_owner=winner.
  - First grant appears 1 cycle after request.
- ARB_BUSY, owner's i_req low:
  - If another request is pending, hand over directly at next edge to the new winner (no idle cycle).
  - Otherwise go to ARB_IDLE with o_gnt=0.
- ARB_BUSY, owner's i_req high: keep grant (subject to the optional feature).
- Slave drive (combinational):
  - if_bus.addr and wr_data = owner's inputs.
  - if_bus.rd_req and wr_req = owner's strobes AND o_gnt[owner].
  - In ARB_IDLE all strobes are 0; addr and wr_data are 0.
  - Strobes from non-granted masters are ignored.
  - rd_req and wr_req both high: forwarded unchanged (slave defines the behaviour).
- Read return:
  - RD_LAT-deep shift register of {valid, owner index}; entry = {if_bus.rd_req, r_owner}.
  - At the output: o_rd_vld = onehot(idx) if valid; o_rd_data = if_bus.rd_data.
  - Read return continues after a grant changes; in-flight reads still reach the original issuer.
- Reset mid-access: in-flight reads are dropped; no o_rd_vld after reset.
- Pointer arithmetic: index wraps from N_MST-1 to 0; width $clog2(N_MST), minimum 1.

Optional Feature:
- Macro: SIMPLE_BUS_ARB_QUOTA_EN.
- Defined:
  - Counter r_quota_cnt is cleared on each new grant and increments every ARB_BUSY cycle.
  - When r_quota_cnt==QUOTA-1 and another master requests, grant rotates at the next edge even if the owner's i_req is still high.
  - Pre-empted owner must tolerate losing grant with no notice; strobes issued in the last granted cycle are honoured.
  - With no other requester, the counter saturates and the owner keeps the grant.
- Not defined: grant is held until the owner drops i_req; QUOTA is unused.

Decomposition:
- Package simple_bus_arb_pkg holds:
  - arb_state_e {ARB_IDLE, ARB_BUSY}.
  - Function rr_pick(req, last) returning the winner index.
  - Localparam function for index width.
- Natural sub-module: simple_bus_rd_tag_pipe (RD_LAT-deep valid+index delay line).

Test Plan:
- Single requester: i_req=4'b0010 from cycle 0 → o_gnt=0010 at cycle 1; write addr 3 data 8'hA5 → if_bus.wr_req=1, addr=3, wr_data=A5 in the same cycle.
- Contention: i_req=4'b1111 held, each master drops its request after 2 granted cycles → grant order 0001,0010,0100,1000,0001 with no idle cycles between.
- Read routing, RD_LAT=2: master 2 reads addr 1 at cycle t, then grant moves to master 3 → o_rd_vld=0100 and o_rd_data=slave data at t+2; master 3 sees no valid.
- Ignored strobe: master 1 asserts i_mst_wr_req while o_gnt=0001 → if_bus.wr_req stays 0 for master 1's strobe.
- Async reset mid-read: i_async_rst pulsed between clock edges after rd_req → o_gnt=0 and o_rd_vld=0 immediately; no o_rd_vld after release; first grant after release goes to master 0.
- With SIMPLE_BUS_ARB_QUOTA_EN and QUOTA=4: masters 0 and 1 both hold i_req → o_gnt alternates every 4 cycles; master 0 alone → grant held indefinitely.
